// File: rtl/counter_b32_monitor.sv
// rtl/counter_b32_monitor.sv - in-line scoreboard for the 32-bit up/down/down-by-3/load counter
module counter_b32_monitor #(
    parameter int WIDTH     = 32,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 mon_clk,
    input  logic                 mon_reset,
    input  logic                 mon_enable,
    input  logic [1:0]           mon_mode,
    input  logic [WIDTH-1:0]     mon_D,
    input  logic [WIDTH-1:0]     mon_Q,
    input  logic                 mon_rco,
    input  logic                 mon_load,
    input  logic                 mon_clear,
    output logic                 mon_err,
    output logic                 mon_err_sticky,
    output logic [2:0]           mon_err_code,
    output logic [WIDTH-1:0]     mon_first_err_q,
    output logic [ERR_CNT_W-1:0] mon_err_cnt,
    output logic [31:0]          mon_check_cnt
);

    typedef enum logic {
        ST_WAIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_e;

    localparam logic [1:0]           MODE_UP    = 2'b00;
    localparam logic [1:0]           MODE_DOWN  = 2'b01;
    localparam logic [1:0]           MODE_DOWN3 = 2'b10;
    localparam logic [WIDTH-1:0]     Q_ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0]     Q_THREE    = WIDTH'(3);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE    = ERR_CNT_W'(1);
    localparam logic [31:0]          CHK_ONE    = 32'd1;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       model_q_q, model_q_d;
    logic                   model_rco_q, model_rco_d;
    logic                   model_load_q, model_load_d;
    logic                   err_q, err_d;
    logic [2:0]             err_code_q, err_code_d;
    logic                   sticky_q, sticky_d;
    logic [WIDTH-1:0]       first_q_q, first_q_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [31:0]            check_cnt_q, check_cnt_d;

    logic [WIDTH-1:0]       exp_q;
    logic                   exp_rco;
    logic                   exp_load;
    logic [2:0]             mismatch;

    always_comb begin
        // WAIT always checks the post-reset values of the counter
        if (state_q == ST_WAIT) begin
            exp_q    = '0;
            exp_rco  = 1'b0;
            exp_load = 1'b0;
        end else begin
            exp_q    = model_q_q;
            exp_rco  = model_rco_q;
            exp_load = model_load_q;
        end
        mismatch = {mon_load != exp_load, mon_rco != exp_rco, mon_Q != exp_q};
    end

    always_comb begin
        model_q_d    = model_q_q;
        model_rco_d  = 1'b0;
        model_load_d = 1'b0;
        if (mon_enable) begin
            case (mon_mode)
                MODE_UP: begin
                    model_q_d   = model_q_q + Q_ONE;
                    model_rco_d = (model_q_q == '1);
                end
                MODE_DOWN: begin
                    model_q_d   = model_q_q - Q_ONE;
                    model_rco_d = (model_q_q == '0);
                end
                MODE_DOWN3: begin
                    model_q_d   = model_q_q - Q_THREE;
                    model_rco_d = (model_q_q < Q_THREE);
                end
                default: begin
                    model_q_d    = mon_D;
                    model_load_d = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        state_d     = ST_TRACK;
        err_d       = |mismatch;
        err_code_d  = mismatch;
        sticky_d    = sticky_q;
        first_q_d   = first_q_q;
        err_cnt_d   = err_cnt_q;
        check_cnt_d = check_cnt_q;
        // clear outranks a same-edge error for the status, not for the pulse
        if (mon_clear) begin
            sticky_d    = 1'b0;
            first_q_d   = '0;
            err_cnt_d   = '0;
            check_cnt_d = '0;
        end else begin
            if (check_cnt_q != '1) begin
                check_cnt_d = check_cnt_q + CHK_ONE;
            end
            if (err_d) begin
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + ERR_ONE;
                end
                if (!sticky_q) begin
                    sticky_d  = 1'b1;
                    first_q_d = mon_Q;
                end
            end
        end
    end

    always_ff @(posedge mon_clk) begin
        if (mon_reset) begin
            state_q      <= ST_WAIT;
            model_q_q    <= '0;
            model_rco_q  <= 1'b0;
            model_load_q <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= '0;
            sticky_q     <= 1'b0;
            first_q_q    <= '0;
            err_cnt_q    <= '0;
            check_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            model_q_q    <= model_q_d;
            model_rco_q  <= model_rco_d;
            model_load_q <= model_load_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            sticky_q     <= sticky_d;
            first_q_q    <= first_q_d;
            err_cnt_q    <= err_cnt_d;
            check_cnt_q  <= check_cnt_d;
        end
    end

    assign mon_err         = err_q;
    assign mon_err_code    = err_code_q;
    assign mon_err_sticky  = sticky_q;
    assign mon_first_err_q = first_q_q;
    assign mon_err_cnt     = err_cnt_q;
    assign mon_check_cnt   = check_cnt_q;

endmodule

// File: doc/counter_b32_monitor.md
Name: counter_b32_monitor

Overview:
- Synthesizable in-line checker that sits on the output side of the 32-bit up/down/down-by-3/load counter and shares its clock and reset.
- Consumes the same stimulus the counter receives (enable, mode, D), runs its own reference model of the counter, and compares the counter's Q, rco and load against that model every cycle.
- Reports a per-cycle error pulse, sticky error status, an error code, the first failing Q value, and saturating check/error counts.
- Used in simulation benches and in the post-synthesis Qflow flow as the counter's scoreboard.

Parameters:
- WIDTH, 32, data width of the counter under check.
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- mon_clk  input  1  clock; same clock as the counter under check.
- mon_reset  input  1  synchronous, active-high reset; same reset as the counter.
- mon_enable  input  1  copy of the counter's enable.
- mon_mode  input  2  copy of the counter's mode: 00 up 1, 01 down 1, 10 down 3, 11 parallel load.
- mon_D  input  WIDTH  copy of the counter's parallel-load data.
- mon_Q  input  WIDTH  counter Q output.
- mon_rco  input  1  counter rco output.
- mon_load  input  1  counter load output.
- mon_clear  input  1  clears sticky status, counters and capture; does not touch the model.
- mon_err  output  1  one-cycle pulse, high when the previous cycle's comparison failed.
- mon_err_sticky  output  1  set on the first error, held until clear or reset.
- mon_err_code  output  3  [0] Q mismatch, [1] rco mismatch, [2] load mismatch; valid while mon_err is high.
- mon_first_err_q  output  WIDTH  mon_Q value at the first error since reset or clear.
- mon_err_cnt  output  ERR_CNT_W  saturating count of failing cycles.
- mon_check_cnt  output  32  saturating count of compared cycles.

Behaviour:
- Reset (synchronous, active-high; reset is sampled at the clock edge):
  - model Q = 0, model rco = 0, model load = 0;
  - all outputs = 0;
  - FSM enters WAIT.
- Model update at each edge, using the inputs sampled at that edge; mon_enable = 0 means model Q holds, rco = 0, load = 0.
  - Mode 00: Q + 1. rco = 1 only when wrapping from all-ones to 0.
  - Mode 01: Q - 1. rco = 1 only when wrapping from 0 to all-ones.
  - Mode 10: Q - 3 modulo 2^WIDTH. rco = 1 when the old Q < 3, e.g. 1 goes to 0xFFFFFFFE.
  - Modes 00, 01 and 10 all drive load = 0.
  - Mode 11: Q = mon_D, rco = 0, load = 1.
- Comparison and latency:
  - During cycle N+1, the model (updated at edge N) is compared combinationally against mon_Q, mon_rco and mon_load.
  - The result is registered at edge N+1, so mon_err and mon_err_code are visible during cycle N+2.
  - Total latency is one cycle from the counter output to the flag.
- FSM:
  - WAIT: first cycle after reset. Compares against the reset values (0, 0, 0), then goes to TRACK.
  - TRACK: compares every cycle. On a mismatch it stays in TRACK and asserts mon_err.
  - FAULT is not a separate state; sticky status carries it.
- On error:
  - mon_err_cnt increments and saturates at all-ones.
  - If mon_err_sticky was 0: capture mon_first_err_q and set sticky.
  - Later errors do not overwrite the capture.
- mon_check_cnt increments every compared cycle (WAIT and TRACK) and saturates at 0xFFFFFFFF.
- mon_clear:
  - At the next edge it zeroes sticky, first_err_q, err_cnt and check_cnt.
  - If a mismatch is registered at that same edge, the clear wins for the counters, but mon_err still pulses.
  - The model and FSM are unaffected.
- Reset mid-operation: the model returns to 0 and the FSM to WAIT in the same edge as the counter. Any pending mon_err is dropped.
- Modes with mon_enable = 0: mode and D are ignored.

Test Plan:
- Reset, enable=1, mode 00 for 5 cycles -> model and Q step 0,1,2,3,4,5; mon_err=0; check_cnt=6.
- Load 0xFFFFFFFE (mode 11), then mode 00 for 2 cycles:
  - load=1 one cycle;
  - Q goes 0xFFFFFFFF then 0x00000000 with rco=1 on the wrap cycle only;
  - no errors.
- Load 0x00000002, then mode 10 -> Q=0xFFFFFFFF, rco=1; then mode 01 -> Q=0xFFFFFFFE, rco=0; no errors.
- Force mon_Q to 0x00000007 where the model expects 0x00000005:
  - mon_err pulses one cycle later with err_code=001;
  - sticky=1, first_err_q=0x00000007, err_cnt=1.
- Force mon_rco=1 and mon_load=0 on a load cycle -> err_code=110; err_cnt increments; first_err_q unchanged.
- Assert mon_clear, then mon_reset mid-count at Q=0x1234:
  - counters, sticky and capture read 0;
  - next compare expects Q=0 with no error.
